// File: rtl/exe_stage_pipe.sv
// rtl/exe_stage_pipe.sv - execute stage: Val2 shifter, ALU, branch target, iterative MUL, EXE/MEM register
module exe_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 4,
  parameter int IMM_W    = 24,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        exe_cmd,
  input  logic              mul_en,
  input  logic              s_en,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [3:0]        status_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              out_valid,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              wb_en,
  output logic              br_taken,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] br_addr,
  output logic [REG_W-1:0]  dest,
  output logic [3:0]        status_out,
  output logic              status_we
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  localparam int MUL_STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             s_en_q;

  // Operands and controls of the MUL in flight, held until the product is ready
  logic [DATA_W-1:0] mcand, mplier, acc, acc_nx;
  logic              m_mem_read, m_mem_write, m_wb, m_br, m_s_en;
  logic [REG_W-1:0]  m_dest;
  logic [DATA_W-1:0] m_val_rm, m_br_addr;
  logic [1:0]        m_cv;

  logic [DATA_W-1:0] imm_ext, imm_rot_val, sh_val, val2;
  logic [4:0]        imm_rot, sh_amt;

  assign in_ready = (state == IDLE) & ~freeze & ~rst;

  assign imm_ext     = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
  assign imm_rot     = {shift_operand[11:8], 1'b0};
  assign imm_rot_val = (imm_ext >> imm_rot) | (imm_ext << (DATA_W - int'(imm_rot)));
  assign sh_amt      = shift_operand[11:7];

  always_comb begin
    sh_val = val_rm_in;
    case (shift_operand[6:5])
      2'b00:   sh_val = val_rm_in << sh_amt;
      2'b01:   sh_val = val_rm_in >> sh_amt;
      2'b10:   sh_val = $signed(val_rm_in) >>> sh_amt;
      default: sh_val = (val_rm_in >> sh_amt) | (val_rm_in << (DATA_W - int'(sh_amt)));
    endcase
  end

  always_comb begin
    if (mem_read_en_in | mem_write_en_in)
      val2 = {{(DATA_W-12){1'b0}}, shift_operand};
    else if (imm)
      val2 = imm_rot_val;
    else
      val2 = sh_val;
  end

  // Subtraction runs through the adder as Rn + ~Val2 + cin, so C comes out as NOT borrow
  logic              is_sub, add_cin;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W:0]   sum;

  assign is_sub = (exe_cmd == OP_SUB) | (exe_cmd == OP_SBC);
  assign add_b  = is_sub ? ~val2 : val2;

  always_comb begin
    add_cin = 1'b0;
    case (exe_cmd)
      OP_ADC, OP_SBC: add_cin = status_in[3];
      OP_SUB:         add_cin = 1'b1;
      default:        add_cin = 1'b0;
    endcase
  end

  assign sum = {1'b0, val_rn} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

  logic [DATA_W-1:0] alu_out;
  logic              alu_c, alu_v, op_ok;
  logic [3:0]        alu_status;

  always_comb begin
    alu_out = '0;
    alu_c   = status_in[3];
    alu_v   = status_in[2];
    op_ok   = 1'b1;
    case (exe_cmd)
      OP_MOV: alu_out = val2;
      OP_MVN: alu_out = ~val2;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_out = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (val_rn[DATA_W-1] == add_b[DATA_W-1]) & (sum[DATA_W-1] != val_rn[DATA_W-1]);
      end
      OP_AND: alu_out = val_rn & val2;
      OP_ORR: alu_out = val_rn | val2;
      OP_EOR: alu_out = val_rn ^ val2;
      default: begin
        alu_out = '0;
        op_ok   = 1'b0;
      end
    endcase
    alu_status = op_ok ? {alu_c, alu_v, (alu_out == '0), alu_out[DATA_W-1]} : status_in;
  end

  logic [DATA_W-1:0] br_target;
  assign br_target = pc + ({{(DATA_W-IMM_W){signed_imm[IMM_W-1]}}, signed_imm} << 2);

  always_comb begin
    acc_nx = acc;
    for (int b = 0; b < MUL_BITS; b++) begin
      if (mplier[b]) acc_nx = acc_nx + (mcand << b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      wb_en        <= 1'b0;
      br_taken     <= 1'b0;
      s_en_q       <= 1'b0;
      alu_res      <= '0;
      val_rm       <= '0;
      br_addr      <= '0;
      dest         <= '0;
      status_out   <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_wb         <= 1'b0;
      m_br         <= 1'b0;
      m_s_en       <= 1'b0;
      m_dest       <= '0;
      m_val_rm     <= '0;
      m_br_addr    <= '0;
      m_cv         <= '0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      wb_en        <= 1'b0;
      br_taken     <= 1'b0;
      s_en_q       <= 1'b0;
    end else if (!freeze) begin
      if (state == MUL_BUSY) begin
        acc    <= acc_nx;
        mcand  <= mcand << MUL_BITS;
        mplier <= mplier >> MUL_BITS;
        if (cnt == CNT_LAST) begin
          state        <= IDLE;
          out_valid    <= 1'b1;
          alu_res      <= acc_nx;
          mem_read_en  <= m_mem_read;
          mem_write_en <= m_mem_write;
          wb_en        <= m_wb;
          br_taken     <= m_br;
          s_en_q       <= m_s_en;
          dest         <= m_dest;
          val_rm       <= m_val_rm;
          br_addr      <= m_br_addr;
          status_out   <= {m_cv, (acc_nx == '0), acc_nx[DATA_W-1]};
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (in_valid && mul_en) begin
        state       <= MUL_BUSY;
        cnt         <= '0;
        mcand       <= val_rn;
        mplier      <= val_rm_in;
        acc         <= '0;
        m_mem_read  <= mem_read_en_in;
        m_mem_write <= mem_write_en_in;
        m_wb        <= wb_en_in;
        m_br        <= b_in;
        m_s_en      <= s_en;
        m_dest      <= dest_in;
        m_val_rm    <= val_rm_in;
        m_br_addr   <= br_target;
        m_cv        <= status_in[3:2];
        out_valid    <= 1'b0;
        mem_read_en  <= 1'b0;
        mem_write_en <= 1'b0;
        wb_en        <= 1'b0;
        br_taken     <= 1'b0;
        s_en_q       <= 1'b0;
      end else if (in_valid) begin
        out_valid    <= 1'b1;
        mem_read_en  <= mem_read_en_in;
        mem_write_en <= mem_write_en_in;
        wb_en        <= wb_en_in;
        br_taken     <= b_in;
        s_en_q       <= s_en;
        alu_res      <= alu_out;
        val_rm       <= val_rm_in;
        br_addr      <= br_target;
        dest         <= dest_in;
        status_out   <= alu_status;
      end else begin
        out_valid    <= 1'b0;
        mem_read_en  <= 1'b0;
        mem_write_en <= 1'b0;
        wb_en        <= 1'b0;
        br_taken     <= 1'b0;
        s_en_q       <= 1'b0;
      end
    end
  end

  assign status_we = out_valid & s_en_q & ~mem_read_en & ~mem_write_en & ~br_taken;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb/tb_exe_stage_pipe.sv - directed self-checking bench for exe_stage_pipe
module tb_exe_stage_pipe;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 24;
  localparam int MUL_BITS = 1;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, freeze, flush;
  logic [3:0]        exe_cmd;
  logic              mul_en, s_en, mem_read_en_in, mem_write_en_in, wb_en_in, b_in;
  logic [DATA_W-1:0] pc, val_rn, val_rm_in;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [IMM_W-1:0]  signed_imm;
  logic [3:0]        status_in;
  logic [REG_W-1:0]  dest_in;
  logic              out_valid, mem_read_en, mem_write_en, wb_en, br_taken;
  logic [DATA_W-1:0] alu_res, val_rm, br_addr;
  logic [REG_W-1:0]  dest;
  logic [3:0]        status_out;
  logic              status_we;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_stage_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .IMM_W(IMM_W), .MUL_BITS(MUL_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .freeze(freeze), .flush(flush),
    .exe_cmd(exe_cmd), .mul_en(mul_en), .s_en(s_en), .mem_read_en_in(mem_read_en_in),
    .mem_write_en_in(mem_write_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .pc(pc), .val_rn(val_rn),
    .val_rm_in(val_rm_in), .imm(imm), .shift_operand(shift_operand), .signed_imm(signed_imm),
    .status_in(status_in), .dest_in(dest_in), .out_valid(out_valid), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .wb_en(wb_en), .br_taken(br_taken), .alu_res(alu_res),
    .val_rm(val_rm), .br_addr(br_addr), .dest(dest), .status_out(status_out), .status_we(status_we)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; freeze = 0; flush = 0; exe_cmd = 4'b0000; mul_en = 0; s_en = 0;
    mem_read_en_in = 0; mem_write_en_in = 0; wb_en_in = 0; b_in = 0;
    pc = '0; val_rn = '0; val_rm_in = '0; imm = 0; shift_operand = '0;
    signed_imm = '0; status_in = '0; dest_in = '0;
  endtask

  initial begin
    int c;
    int bad;
    rst = 1;
    clear_in();
    in_valid = 1;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_res", alu_res, 32'h0);
    chk("rst_status_we", 32'(status_we), 32'd0);
    rst = 0; in_valid = 0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // ADD with rotated immediate 0xFF ror 4
    exe_cmd = 4'b0010; imm = 1; shift_operand = 12'h2FF; val_rn = 32'd1; s_en = 1; wb_en_in = 1;
    dest_in = 4'd3; in_valid = 1;
    step(); clear_in();
    chk("add_alu_res", alu_res, 32'hF0000010);
    chk("add_status", 32'(status_out), 32'b0001);
    chk("add_status_we", 32'(status_we), 32'd1);
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_dest", 32'(dest), 32'd3);
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_status_we", 32'(status_we), 32'd0);
    chk("idle_wb_en", 32'(wb_en), 32'd0);
    chk("idle_alu_hold", alu_res, 32'hF0000010);

    // CMP 5,5
    exe_cmd = 4'b0100; s_en = 1; val_rn = 32'd5; val_rm_in = 32'd5; in_valid = 1;
    step(); clear_in();
    chk("cmp_alu_res", alu_res, 32'h0);
    chk("cmp_status", 32'(status_out), 32'b1010);
    chk("cmp_wb_en", 32'(wb_en), 32'd0);

    // MOV with ASR #4
    exe_cmd = 4'b0001; shift_operand = 12'h240; val_rm_in = 32'h80000000; in_valid = 1;
    step(); clear_in();
    chk("mov_asr", alu_res, 32'hF8000000);
    chk("mov_status_we", 32'(status_we), 32'd0);

    // ADD signed overflow
    exe_cmd = 4'b0010; imm = 1; shift_operand = 12'h001; val_rn = 32'h7FFFFFFF; s_en = 1; in_valid = 1;
    step(); clear_in();
    chk("add_ovf_res", alu_res, 32'h80000000);
    chk("add_ovf_status", 32'(status_out), 32'b0101);

    // SBC 0 - 0 - ~C with C=0 and C=1
    exe_cmd = 4'b0101; imm = 1; s_en = 1; in_valid = 1;
    step(); clear_in();
    chk("sbc_c0_res", alu_res, 32'hFFFFFFFF);
    chk("sbc_c0_status", 32'(status_out), 32'b0001);
    exe_cmd = 4'b0101; imm = 1; s_en = 1; status_in = 4'b1000; in_valid = 1;
    step(); clear_in();
    chk("sbc_c1_res", alu_res, 32'h0);
    chk("sbc_c1_status", 32'(status_out), 32'b1010);

    // Unknown opcode keeps flags
    exe_cmd = 4'b1111; val_rn = 32'h55; s_en = 1; status_in = 4'b1100; in_valid = 1;
    step(); clear_in();
    chk("bad_op_res", alu_res, 32'h0);
    chk("bad_op_status", 32'(status_out), 32'b1100);

    // Load address uses the 12-bit offset
    exe_cmd = 4'b0010; mem_read_en_in = 1; imm = 1; shift_operand = 12'hFFF; val_rn = 32'h1000;
    s_en = 1; wb_en_in = 1; in_valid = 1;
    step(); clear_in();
    chk("ldr_addr", alu_res, 32'h1FFF);
    chk("ldr_mem_read", 32'(mem_read_en), 32'd1);
    chk("ldr_status_we", 32'(status_we), 32'd0);
    step();
    chk("ldr_mem_read_clear", 32'(mem_read_en), 32'd0);

    // MUL 0xFFFFFFFF * 3
    mul_en = 1; val_rn = 32'hFFFFFFFF; val_rm_in = 32'd3; s_en = 1; wb_en_in = 1; status_in = 4'b0100;
    in_valid = 1;
    step(); clear_in();
    c = 1; bad = 0;
    while (!out_valid && c < 100) begin
      if (in_ready) bad++;
      step(); c++;
    end
    chk("mul_latency", 32'(c), 32'd33);
    chk("mul_in_ready_low", 32'(bad), 32'd0);
    chk("mul_res", alu_res, 32'hFFFFFFFD);
    chk("mul_status", 32'(status_out), 32'b0101);
    chk("mul_status_we", 32'(status_we), 32'd1);
    chk("mul_done_ready", 32'(in_ready), 32'd1);
    step();
    chk("mul_once", 32'(out_valid), 32'd0);

    // MUL with a 5-cycle freeze in the middle
    mul_en = 1; val_rn = 32'h12345678; val_rm_in = 32'h10; status_in = 4'b1000; in_valid = 1;
    step(); clear_in();
    c = 1;
    while (!out_valid && c < 100) begin
      freeze = (c >= 10 && c < 15);
      step(); c++;
    end
    freeze = 0;
    chk("mul_frz_latency", 32'(c), 32'd38);
    chk("mul_frz_res", alu_res, 32'h23456780);
    chk("mul_frz_status", 32'(status_out), 32'b1000);
    step();

    // Flush on the 10th busy cycle
    mul_en = 1; val_rn = 32'd7; val_rm_in = 32'd9; wb_en_in = 1; in_valid = 1;
    step(); clear_in();
    for (int i = 0; i < 9; i++) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_wb_en", 32'(wb_en), 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) bad++;
    end
    chk("flush_no_result", 32'(bad), 32'd0);
    chk("flush_alu_hold", alu_res, 32'h23456780);

    // Backward branch
    b_in = 1; pc = 32'h100; signed_imm = 24'hFFFFFE; s_en = 1; in_valid = 1;
    step(); clear_in();
    chk("br_addr", br_addr, 32'hF8);
    chk("br_taken", 32'(br_taken), 32'd1);
    chk("br_status_we", 32'(status_we), 32'd0);
    step();
    chk("br_taken_once", 32'(br_taken), 32'd0);
    b_in = 1; pc = 32'h200; signed_imm = 24'h000004; freeze = 1; in_valid = 1;
    #1;
    chk("br_frz_in_ready", 32'(in_ready), 32'd0);
    step(); clear_in();
    chk("br_frz_taken", 32'(br_taken), 32'd0);
    chk("br_frz_addr", br_addr, 32'hF8);

    // Freeze holds a valid result
    exe_cmd = 4'b0010; imm = 1; shift_operand = 12'h001; val_rn = 32'd7; wb_en_in = 1; in_valid = 1;
    step(); clear_in();
    val_rn = 32'd100; exe_cmd = 4'b0010; freeze = 1; in_valid = 1;
    step(); clear_in();
    chk("frz_hold_valid", 32'(out_valid), 32'd1);
    chk("frz_hold_res", alu_res, 32'd8);
    chk("frz_hold_wb", 32'(wb_en), 32'd1);
    step();
    chk("frz_release", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL
    mul_en = 1; val_rn = 32'd3; val_rm_in = 32'd3; in_valid = 1;
    step(); clear_in();
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("rst_mul_res", alu_res, 32'h0);
    chk("rst_mul_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) bad++;
    end
    chk("rst_mul_no_result", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
